// File: rtl/quad_step_decoder.sv
// Quadrature A/B decoder: synchronises the encoder phases, decodes Gray-code
// steps into a wrapping up/down position counter and flags illegal jumps.
module quad_step_decoder #(
    parameter int unsigned CNT_WIDTH   = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 quad_a,
    input  logic                 quad_b,
    input  logic                 load_en,
    input  logic [CNT_WIDTH-1:0] counter_in,
    input  logic                 clr_err,
    output logic [CNT_WIDTH-1:0] counter_out,
    output logic                 dir,
    output logic                 step_pulse,
    output logic                 err_pulse,
    output logic                 err_flag
);

    localparam int unsigned ARM_W = $clog2(SYNC_STAGES + 2);
    localparam logic [ARM_W-1:0] ARM_INIT = ARM_W'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] sync_a;
    logic [SYNC_STAGES-1:0] sync_b;
    logic [1:0]             cur_ab;
    logic [1:0]             prev_ab;
    logic [ARM_W-1:0]       arm_cnt;

    logic                   step_up;
    logic                   step_down;
    logic                   illegal;
    logic [CNT_WIDTH-1:0]   counter_nxt;
    logic                   dir_nxt;
    logic                   err_flag_nxt;

    assign cur_ab = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};

    // Gray-code transition decode; suppressed until the arm counter drains
    always_comb begin
        step_up   = 1'b0;
        step_down = 1'b0;
        illegal   = 1'b0;
        if (arm_cnt == '0) begin
            case ({prev_ab, cur_ab})
                4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step_up   = 1'b1;
                4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step_down = 1'b1;
                4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: illegal   = 1'b1;
                default: ;
            endcase
        end
    end

    // Next counter/direction/error state; load beats a step, error set beats clear
    always_comb begin
        counter_nxt  = counter_out;
        dir_nxt      = dir;
        err_flag_nxt = err_flag;

        if (load_en) begin
            counter_nxt = counter_in;
        end else if (step_up) begin
            counter_nxt = counter_out + CNT_WIDTH'(1);
        end else if (step_down) begin
            counter_nxt = counter_out - CNT_WIDTH'(1);
        end

        if (step_up) begin
            dir_nxt = 1'b1;
        end else if (step_down) begin
            dir_nxt = 1'b0;
        end

        if (illegal) begin
            err_flag_nxt = 1'b1;
        end else if (clr_err) begin
            err_flag_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a      <= '0;
            sync_b      <= '0;
            prev_ab     <= 2'b00;
            arm_cnt     <= ARM_INIT;
            counter_out <= '0;
            dir         <= 1'b1;
            step_pulse  <= 1'b0;
            err_pulse   <= 1'b0;
            err_flag    <= 1'b0;
        end else begin
            sync_a      <= {sync_a[SYNC_STAGES-2:0], quad_a};
            sync_b      <= {sync_b[SYNC_STAGES-2:0], quad_b};
            prev_ab     <= cur_ab;
            if (arm_cnt != '0) begin
                arm_cnt <= arm_cnt - ARM_W'(1);
            end
            counter_out <= counter_nxt;
            dir         <= dir_nxt;
            step_pulse  <= step_up | step_down;
            err_pulse   <= illegal;
            err_flag    <= err_flag_nxt;
        end
    end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench for quad_step_decoder: an 8-bit and a 3-bit counter instance
// share all stimulus so wrap behaviour is visible alongside the wide count.
module tb_quad_step_decoder;

    logic       clk;
    logic       reset;
    logic       quad_a;
    logic       quad_b;
    logic       load_en;
    logic [7:0] cin;
    logic       clr_err;

    logic [7:0] cnt8;
    logic       dir8;
    logic       step8;
    logic       errp8;
    logic       errf8;

    logic [2:0] cnt3;
    logic       dir3;
    logic       step3;
    logic       errp3;
    logic       errf3;

    int n_checks = 0;
    int n_fail   = 0;
    int n_step;
    int n_err;
    int step_at;
    int total;

    logic [1:0] up_seq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};

    quad_step_decoder #(.CNT_WIDTH(8), .SYNC_STAGES(2)) dut8 (
        .clk(clk), .reset(reset), .quad_a(quad_a), .quad_b(quad_b),
        .load_en(load_en), .counter_in(cin), .clr_err(clr_err),
        .counter_out(cnt8), .dir(dir8), .step_pulse(step8),
        .err_pulse(errp8), .err_flag(errf8)
    );

    quad_step_decoder #(.CNT_WIDTH(3), .SYNC_STAGES(2)) dut3 (
        .clk(clk), .reset(reset), .quad_a(quad_a), .quad_b(quad_b),
        .load_en(load_en), .counter_in(cin[2:0]), .clr_err(clr_err),
        .counter_out(cnt3), .dir(dir3), .step_pulse(step3),
        .err_pulse(errp3), .err_flag(errf3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Hold pins at ab for ncyc cycles, tallying pulses seen at each falling edge
    task automatic drive(input logic [1:0] ab, input int ncyc);
        {quad_a, quad_b} = ab;
        n_step  = 0;
        n_err   = 0;
        step_at = 0;
        for (int i = 1; i <= ncyc; i++) begin
            @(negedge clk);
            if (step8) begin
                n_step++;
                if (step_at == 0) step_at = i;
            end
            if (errp8) n_err++;
        end
    endtask

    initial begin
        reset   = 1'b1;
        quad_a  = 1'b1;
        quad_b  = 1'b1;
        load_en = 1'b0;
        cin     = 8'd0;
        clr_err = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_cnt8", 32'(cnt8), 32'd0);
        check("rst_cnt3", 32'(cnt3), 32'd0);
        check("rst_dir", 32'(dir8), 32'd1);
        check("rst_step", 32'(step8), 32'd0);
        check("rst_errp", 32'(errp8), 32'd0);
        check("rst_errf", 32'(errf8), 32'd0);

        // Pins at 11 out of reset must not produce any event
        reset = 1'b0;
        drive(2'b11, 10);
        check("idle_step", 32'(n_step), 32'd0);
        check("idle_err", 32'(n_err), 32'd0);
        check("idle_cnt", 32'(cnt8), 32'd0);
        check("idle_errf", 32'(errf8), 32'd0);

        reset = 1'b1;
        {quad_a, quad_b} = 2'b00;
        @(negedge clk);
        reset = 1'b0;
        drive(2'b00, 6);
        check("arm00_step", 32'(n_step), 32'd0);

        // Four full up cycles; each step appears on the 3rd falling edge
        total = 0;
        for (int c = 0; c < 4; c++) begin
            for (int t = 0; t < 4; t++) begin
                drive(up_seq[t], 4);
                total += n_step;
                check("up_lat", 32'(step_at), 32'd3);
            end
        end
        check("up_total", 32'(total), 32'd16);
        check("up_cnt8", 32'(cnt8), 32'd16);
        check("up_cnt3", 32'(cnt3), 32'd0);
        check("up_dir", 32'(dir8), 32'd1);
        check("up_errf", 32'(errf8), 32'd0);

        load_en = 1'b1;
        cin     = 8'd6;
        @(negedge clk);
        load_en = 1'b0;
        check("ld_cnt8", 32'(cnt8), 32'd6);
        check("ld_cnt3", 32'(cnt3), 32'd6);

        drive(2'b10, 4);
        check("w_up1_8", 32'(cnt8), 32'd7);
        check("w_up1_3", 32'(cnt3), 32'd7);
        drive(2'b11, 4);
        check("w_up2_8", 32'(cnt8), 32'd8);
        check("w_up2_3", 32'(cnt3), 32'd0);
        drive(2'b01, 4);
        check("w_up3_8", 32'(cnt8), 32'd9);
        check("w_up3_3", 32'(cnt3), 32'd1);
        drive(2'b11, 4);
        check("w_dn1_8", 32'(cnt8), 32'd8);
        check("w_dn1_3", 32'(cnt3), 32'd0);
        check("w_dn1_dir", 32'(dir8), 32'd0);
        check("w_dn1_dir3", 32'(dir3), 32'd0);
        drive(2'b10, 4);
        check("w_dn2_8", 32'(cnt8), 32'd7);
        check("w_dn2_3", 32'(cnt3), 32'd7);

        // 10->00 is a down step, then 00->11 is illegal
        drive(2'b00, 4);
        check("dn_cnt8", 32'(cnt8), 32'd6);
        drive(2'b11, 4);
        check("ill_errp", 32'(n_err), 32'd1);
        check("ill_step", 32'(n_step), 32'd0);
        check("ill_errf", 32'(errf8), 32'd1);
        check("ill_cnt8", 32'(cnt8), 32'd6);
        check("ill_dir", 32'(dir8), 32'd0);
        drive(2'b01, 4);
        check("resync_cnt8", 32'(cnt8), 32'd7);
        check("resync_dir", 32'(dir8), 32'd1);
        check("resync_errf", 32'(errf8), 32'd1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("clr_errf", 32'(errf8), 32'd0);

        // Load lands on the same edge as the decoded 01->00 up step
        {quad_a, quad_b} = 2'b00;
        repeat (2) @(negedge clk);
        load_en = 1'b1;
        cin     = 8'd5;
        @(negedge clk);
        check("ldstep_cnt8", 32'(cnt8), 32'd5);
        check("ldstep_cnt3", 32'(cnt3), 32'd5);
        check("ldstep_step", 32'(step8), 32'd1);
        check("ldstep_dir", 32'(dir8), 32'd1);
        load_en = 1'b0;

        // Illegal 00->11 decoded on the same edge as clr_err: set wins
        {quad_a, quad_b} = 2'b11;
        repeat (2) @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        check("setwin_errp", 32'(errp8), 32'd1);
        check("setwin_errf", 32'(errf8), 32'd1);
        check("setwin_cnt8", 32'(cnt8), 32'd5);
        clr_err = 1'b0;
        @(negedge clk);
        check("setwin_errp_off", 32'(errp8), 32'd0);
        check("setwin_errf_hold", 32'(errf8), 32'd1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("setwin_clr", 32'(errf8), 32'd0);

        // Reach 9 with pins at 01, then reset mid-sequence
        load_en = 1'b1;
        cin     = 8'd8;
        @(negedge clk);
        load_en = 1'b0;
        drive(2'b01, 4);
        check("pre_rst_cnt8", 32'(cnt8), 32'd9);
        check("pre_rst_cnt3", 32'(cnt3), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_cnt8", 32'(cnt8), 32'd0);
        check("mid_rst_cnt3", 32'(cnt3), 32'd0);
        check("mid_rst_dir", 32'(dir8), 32'd1);
        drive(2'b01, 8);
        check("rearm_step", 32'(n_step), 32'd0);
        check("rearm_err", 32'(n_err), 32'd0);
        check("rearm_cnt8", 32'(cnt8), 32'd0);
        drive(2'b00, 4);
        check("post_cnt8", 32'(cnt8), 32'd1);
        check("post_cnt3", 32'(cnt3), 32'd1);
        check("post_lat", 32'(step_at), 32'd3);
        check("post_dir", 32'(dir8), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
